// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int unsigned PORT_FETCH = 0;
    localparam int unsigned PORT_DBG   = 1;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
    localparam int unsigned DEF_MEM_BYTES = 16384;

endpackage

// File: rtl/imem_arb_picker.sv
// Two-way request picker: a lone requester always wins; on contention the
// port named by prio_i wins. Output grant is one-hot or zero.
module imem_arb_picker
    import imem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = prio_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Two-port instruction-memory arbiter, one transaction in flight at a time.
// Define IMEM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed fetch priority.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned MEM_BYTES = DEF_MEM_BYTES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][31:0] req_addr,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_err,
    output logic             mem_en,
    output logic [31:0]      mem_addr,
    input  logic [31:0]      mem_rdata
);

    state_e      state_q, state_d;
    logic        port_q, port_d;
    logic        err_q, err_d;
    logic [31:0] data_q, data_d;
    logic        prio;
    logic [1:0]  gnt;
    logic        win;
    logic [31:0] sel_addr;
    logic        addr_bad;
    logic        mem_en_raw;
    logic [31:0] mem_addr_raw;

`ifdef IMEM_ARB_ROUND_ROBIN_EN
    logic prio_q, prio_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= PORT_FETCH[0];
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (state_q == IDLE && (|gnt)) begin
            prio_d = ~win;
        end
    end

    assign prio = prio_q;
`else
    assign prio = PORT_FETCH[0];
`endif

    imem_arb_picker u_picker (
        .req_i  (req_valid),
        .prio_i (prio),
        .gnt_o  (gnt)
    );

    assign win      = gnt[1];
    assign sel_addr = req_addr[win];

    // 33-bit compare so a window ending at or past 2^32 is still bounded correctly.
    always_comb begin
        logic [32:0] addr_ext;
        logic [32:0] base_ext;
        logic [32:0] limit_ext;
        addr_ext  = {1'b0, sel_addr};
        base_ext  = {1'b0, BASE_ADDR};
        limit_ext = base_ext + 33'(MEM_BYTES);
        addr_bad  = (addr_ext < base_ext)
                 || ((addr_ext + 33'd3) >= limit_ext)
                 || (sel_addr[1:0] != 2'b00);
    end

    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        err_d        = err_q;
        data_d       = data_q;
        mem_en_raw   = 1'b0;
        mem_addr_raw = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    port_d = win;
                    if (addr_bad) begin
                        err_d   = 1'b1;
                        data_d  = 32'h0;
                        state_d = RESP;
                    end else begin
                        err_d        = 1'b0;
                        mem_en_raw   = 1'b1;
                        mem_addr_raw = sel_addr;
                        state_d      = ACCESS;
                    end
                end
            end
            ACCESS: begin
                data_d  = mem_rdata;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready[port_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            port_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    // Grant-cycle outputs are combinational; rst_n masks them while reset is held.
    assign req_ready = (state_q == IDLE) ? (gnt & {2{rst_n}}) : 2'b00;
    assign mem_en    = mem_en_raw & rst_n;
    assign mem_addr  = rst_n ? mem_addr_raw : 32'h0;
    assign rsp_valid = (state_q == RESP) ? (port_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: transaction-level model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_imem_arbiter;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int unsigned MEMB = 16384;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_addr;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic             mem_en;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_rdata;

    int n_total = 0;
    int n_pass  = 0;

    imem_arbiter #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h8000_0010) return 32'h0000_0013;
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic model_err(input logic [31:0] a);
        longint unsigned x;
        x = longint'(a);
        return (x < longint'(BASE)) || (x + 3 >= longint'(BASE) + longint'(MEMB)) || ((x % 4) != 0);
    endfunction

    // Memory: word appears in the cycle after mem_en; garbage otherwise.
    always @(posedge clk) mem_rdata <= mem_en ? mem_f(mem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Transaction-level model: one job at a time, response visible after a fixed latency.
    logic        m_busy = 1'b0;
    int          m_age  = 0;
    logic        m_port = 1'b0;
    logic        m_errf = 1'b0;
    logic [31:0] m_data = 32'h0;
    logic        m_prio = 1'b0;

    always @(negedge clk) begin : model
        logic w;
        logic e;
        int   lat;
        if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 32'h0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("rst_rsp_data", rsp_data, 32'h0);
            chk("rst_rsp_err", 32'(rsp_err), 32'h0);
            chk("rst_mem_en", 32'(mem_en), 32'h0);
            chk("rst_mem_addr", mem_addr, 32'h0);
            m_busy = 1'b0;
            m_prio = 1'b0;
        end else if (!m_busy) begin
            w = req_valid[1];
            if (req_valid == 2'b11) begin
`ifdef IMEM_ARB_ROUND_ROBIN_EN
                w = m_prio;
`else
                w = 1'b0;
`endif
            end
            chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
            if (|req_valid) begin
                e = model_err(req_addr[w]);
                chk("grant_req_ready", 32'(req_ready), w ? 32'h2 : 32'h1);
                chk("grant_mem_en", 32'(mem_en), e ? 32'h0 : 32'h1);
                if (!e) chk("grant_mem_addr", mem_addr, req_addr[w]);
                m_busy = 1'b1;
                m_age  = 0;
                m_port = w;
                m_errf = e;
                m_data = e ? 32'h0 : mem_f(req_addr[w]);
                m_prio = ~w;
            end else begin
                chk("idle_req_ready", 32'(req_ready), 32'h0);
                chk("idle_mem_en", 32'(mem_en), 32'h0);
            end
        end else begin
            m_age++;
            lat = m_errf ? 1 : 2;
            chk("busy_req_ready", 32'(req_ready), 32'h0);
            chk("busy_mem_en", 32'(mem_en), 32'h0);
            if (m_age >= lat) begin
                chk("rsp_valid", 32'(rsp_valid), m_port ? 32'h2 : 32'h1);
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_err", 32'(rsp_err), 32'(m_errf));
                if (rsp_ready[m_port]) m_busy = 1'b0;
            end else begin
                chk("wait_rsp_valid", 32'(rsp_valid), 32'h0);
            end
        end
    end

    task automatic wait_grant(input int p, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[p]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("grant");
    endtask

    task automatic txn(input int p, input logic [31:0] a, input logic exp_err, input logic [31:0] exp_data);
        bit ok;
        int n;
        @(posedge clk); #1;
        req_valid[p] = 1'b1;
        req_addr[p]  = a;
        wait_grant(p, ok);
        if (!ok) return;
        chk("txn_mem_en", 32'(mem_en), exp_err ? 32'h0 : 32'h1);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        n  = 1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid[p]) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) begin
            timeout("txn_rsp");
            return;
        end
        chk("txn_latency", 32'(n), exp_err ? 32'd1 : 32'd2);
        chk("txn_rsp_data", rsp_data, exp_data);
        chk("txn_rsp_err", 32'(rsp_err), 32'(exp_err));
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int gcount;
        int exp_p;
        int got_p;
        rst_n       = 1'b0;
        req_valid   = 2'b11;
        req_addr[0] = 32'h8000_0000;
        req_addr[1] = 32'h8000_0020;
        rsp_ready   = 2'b11;
        repeat (3) @(negedge clk);
        req_valid = 2'b10;

        // First request granted in the first clock after reset release.
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_grant", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (2) @(posedge clk);

        txn(0, 32'h8000_0010, 1'b0, 32'h0000_0013);
        txn(1, 32'h7FFF_FFFC, 1'b1, 32'h0);
        txn(1, 32'h8000_4000, 1'b1, 32'h0);
        txn(1, 32'h8000_0002, 1'b1, 32'h0);
        txn(1, 32'hFFFF_FFFC, 1'b1, 32'h0);
        txn(0, 32'h8000_3FFC, 1'b0, 32'h8000_3FFC ^ 32'hA5A5_0000);

        // Contention: grants every third cycle; last grant went to port 0.
        @(posedge clk); #1;
        req_addr[0] = 32'h8000_0100;
        req_addr[1] = 32'h8000_0104;
        req_valid   = 2'b11;
        gcount = 0;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
        exp_p = 1;
`else
        exp_p = 0;
`endif
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (|req_ready) begin
                got_p = req_ready[1] ? 1 : 0;
                chk("contend_port", 32'(got_p), 32'(exp_p));
                gcount++;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
                exp_p = 1 - exp_p;
`endif
            end
        end
        chk("contend_count", 32'(gcount), 32'd4);
        @(posedge clk); #1;
        req_valid = 2'b00;

        // Backpressure on port 0 with port 1 waiting.
        rsp_ready   = 2'b10;
        req_addr[0] = 32'h8000_0040;
        req_valid   = 2'b01;
        wait_grant(0, ok);
        @(posedge clk); #1;
        req_valid   = 2'b10;
        req_addr[1] = 32'h8000_0044;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_rsp_data", rsp_data, 32'h8000_0040 ^ 32'hA5A5_0000);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
        end
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("bp_handshake_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        chk("bp_next_grant", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (2) @(posedge clk);

        // Reset asserted while port 0 is in ACCESS.
        #1;
        req_addr[0] = 32'h8000_0080;
        req_valid   = 2'b01;
        wait_grant(0, ok);
        @(posedge clk); #1;
        req_valid   = 2'b10;
        req_addr[1] = 32'h8000_0084;
        rst_n       = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midrst_mem_en", 32'(mem_en), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_first_grant", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000: first byte address of instruction memory.
REQ-002 SHALL have parameter MEM_BYTES, default 16384: instruction memory size in bytes, power of two.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req_valid / req_ready  input / output  2 / 2  per-requester request handshake; index 0 = fetch, index 1 = debug/data.
REQ-006 SHALL have port req_addr  input  2x32  per-requester byte address.
REQ-007 SHALL have ports rsp_valid / rsp_ready  output / input  2 / 2  per-requester response handshake.
REQ-008 SHALL have ports rsp_data / rsp_err  output  32 / 1  shared response word and error flag; meaningful only for the port with rsp_valid high.
REQ-009 SHALL have ports mem_en / mem_addr  output  1 / 32  memory read enable and byte address.
REQ-010 SHALL have port mem_rdata  input  32  memory read word, valid in the cycle after mem_en.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, RESP, with exactly one transaction outstanding.
REQ-012 SHALL, in IDLE only, assert req_ready for exactly the arbitration winner among ports with req_valid high; req_ready SHALL be 0 in ACCESS and RESP.
REQ-013 SHALL record the winning port index and treat the req_valid && req_ready cycle as grant cycle N.
REQ-014 SHALL, for an in-range word-aligned address, drive mem_en=1 and mem_addr=req_addr combinationally in cycle N only, then enter ACCESS.
REQ-015 SHALL in ACCESS (cycle N+1) capture mem_rdata into a response register and enter RESP; rsp_valid of the granted port SHALL rise in cycle N+2.
REQ-016 SHALL flag an error when address < BASE_ADDR, address+3 >= BASE_ADDR+MEM_BYTES, or address[1:0] != 0.
REQ-017 SHALL, on an error request, keep mem_en=0, skip ACCESS, and present rsp_err=1, rsp_data=0 with rsp_valid in cycle N+1.
REQ-018 SHALL hold rsp_valid, rsp_data and rsp_err stable in RESP until rsp_ready of the granted port is high, then return to IDLE.
REQ-019 SHALL ignore rsp_ready of the non-granted port; only one rsp_valid bit SHALL be high at any time.
REQ-020 SHALL accept a new request no earlier than the cycle after the response handshake (max one transaction per 3 cycles).
REQ-021 SHALL compute address range checks in 33-bit arithmetic so BASE_ADDR+MEM_BYTES wrap past 2^32 is handled correctly.

Reset
REQ-022 SHALL on rst_n low enter IDLE immediately, regardless of state, and drop any in-flight transaction without a response.
REQ-023 SHALL reset outputs: req_ready=0 during reset, rsp_valid=0, rsp_data=0, rsp_err=0, mem_en=0, mem_addr=0.
REQ-024 SHALL reset the round-robin pointer (when present) so port 0 has priority.
REQ-025 SHALL accept the first request in the first clock after rst_n deasserts.

Configuration
REQ-026 SHALL, with IMEM_ARB_ROUND_ROBIN_EN defined, arbitrate round-robin: after a grant to port k, port 1-k has priority on the next contested arbitration.
REQ-027 SHALL, without IMEM_ARB_ROUND_ROBIN_EN, use fixed priority: port 0 (fetch) always wins when both request, and no pointer register exists.

Structure
REQ-028 SHALL take from a shared package imem_arb_pkg: state enum (IDLE, ACCESS, RESP), port index constants PORT_FETCH=0, PORT_DBG=1, and default BASE_ADDR / MEM_BYTES constants.
REQ-029 SHALL place arbitration in one sub-module imem_arb_picker (inputs: request vector, priority pointer; output: one-hot grant).
REQ-030 SHALL contain no memory storage; the byte array remains in the memory block.

Verification
REQ-031 Single fetch: port0 req 0x8000_0010, mem_rdata=0x0000_0013 -> mem_en in N, rsp_valid[0] in N+2, rsp_data=0x0000_0013, rsp_err=0.
REQ-032 Range error: port1 req 0x7FFF_FFFC -> no mem_en, rsp_valid[1] in N+1, rsp_err=1, rsp_data=0; same for 0x8000_4000 and misaligned 0x8000_0002.
REQ-033 Contention: both ports request continuously -> with macro grants alternate 0,1,0,1; without macro all grants go to port 0.
REQ-034 Backpressure: rsp_ready[0]=0 for 5 cycles -> rsp_valid/rsp_data stable, req_ready=0 throughout, next grant in cycle after handshake.
REQ-035 Reset mid-operation: rst_n low during ACCESS -> rsp_valid=0, mem_en=0 immediately; after release a port1 request is granted in the first cycle.
REQ-036 Boundary: port0 req 0x8000_3FFC -> in range, mem_en=1, rsp_err=0.
